// File: rtl/fp_result_wb_pkg.sv
// Shared FP writeback types: fpnew-style exception status, issue tag and buffered result entry.
package fp_result_wb_pkg;

   localparam int STATUS_W = 5;
   localparam int DATA_W   = 32;
   localparam int RD_W     = 5;

   // Bit order matches the fflags CSR: NV is the MSB, NX the LSB.
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef struct packed {
      logic [RD_W-1:0] rd;
      logic            to_int;
   } tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      status_t           status;
   } res_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with flush; pointers wrap modulo DEPTH, so any depth is allowed.
module fp_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fp_result_wb.sv
// FPU result writeback: pairs in-order issue tags with FPU results and arbitrates
// against FLW load returns for a single registered RF write port per cycle.
module fp_result_wb
   import fp_result_wb_pkg::*;
#(
   parameter int TAG_DEPTH = 4,
   parameter int RES_DEPTH = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [RD_W-1:0]     issue_rd_i,
   input  logic                issue_to_int_i,
   input  logic                fpu_valid_i,
   output logic                fpu_ready_o,
   input  logic [DATA_W-1:0]   fpu_result_i,
   input  logic [STATUS_W-1:0] fpu_status_i,
   input  logic                ld_valid_i,
   input  logic [RD_W-1:0]     ld_rd_i,
   input  logic [DATA_W-1:0]   ld_data_i,
   output logic                frf_we_o,
   output logic [RD_W-1:0]     frf_waddr_o,
   output logic [DATA_W-1:0]   frf_wdata_o,
   output logic                irf_we_o,
   output logic [RD_W-1:0]     irf_waddr_o,
   output logic [DATA_W-1:0]   irf_wdata_o,
   input  logic                flush_i,
   input  logic                fflags_clr_i,
   output logic [STATUS_W-1:0] fflags_o,
   output logic                busy_o,
   output logic                err_o
);

   localparam int TCW = $clog2(TAG_DEPTH + 1);
   localparam int RCW = $clog2(RES_DEPTH + 1);

   tag_t           tag_in, tag_head;
   res_t           res_in, res_head;
   logic           tag_full, tag_empty, res_full, res_empty;
   logic [TCW-1:0] tag_cnt;
   logic [RCW-1:0] res_cnt;
   logic           issue_fire, fpu_fire, drop, res_push, wb_pop;

   assign tag_in = '{rd: issue_rd_i, to_int: issue_to_int_i};
   assign res_in = '{result: fpu_result_i, status: status_t'(fpu_status_i)};

   assign issue_ready_o = !tag_full;
   assign fpu_ready_o   = !res_full;
   assign issue_fire    = issue_valid_i && issue_ready_o && !flush_i;
   assign fpu_fire      = fpu_valid_i && fpu_ready_o && !flush_i;
   // A result with no destination tag (not even one arriving now) cannot be written anywhere.
   assign drop          = fpu_fire && tag_empty && !issue_fire;
   assign res_push      = fpu_fire && !drop;
   assign wb_pop        = !ld_valid_i && !flush_i && !tag_empty && !res_empty;
   assign busy_o        = (tag_cnt != '0) || (res_cnt != '0);

   fp_sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk(clk_i), .rst(rst_i), .flush(flush_i),
      .push(issue_fire), .push_data(tag_in),
      .pop(wb_pop), .pop_data(tag_head),
      .full(tag_full), .empty(tag_empty), .count(tag_cnt)
   );

   fp_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk(clk_i), .rst(rst_i), .flush(flush_i),
      .push(res_push), .push_data(res_in),
      .pop(wb_pop), .pop_data(res_head),
      .full(res_full), .empty(res_empty), .count(res_cnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frf_we_o    <= 1'b0;
         frf_waddr_o <= '0;
         frf_wdata_o <= '0;
         irf_we_o    <= 1'b0;
         irf_waddr_o <= '0;
         irf_wdata_o <= '0;
         err_o       <= 1'b0;
         fflags_o    <= '0;
      end else begin
         frf_we_o    <= 1'b0;
         frf_waddr_o <= '0;
         frf_wdata_o <= '0;
         irf_we_o    <= 1'b0;
         irf_waddr_o <= '0;
         irf_wdata_o <= '0;
         err_o       <= drop;
         if (ld_valid_i) begin
            frf_we_o    <= 1'b1;
            frf_waddr_o <= ld_rd_i;
            frf_wdata_o <= ld_data_i;
         end else if (wb_pop) begin
            if (tag_head.to_int) begin
               irf_we_o    <= 1'b1;
               irf_waddr_o <= tag_head.rd;
               irf_wdata_o <= res_head.result;
            end else begin
               frf_we_o    <= 1'b1;
               frf_waddr_o <= tag_head.rd;
               frf_wdata_o <= res_head.result;
            end
         end
         // Clear and accumulate in one cycle leaves exactly the popped status.
         fflags_o <= (fflags_clr_i ? '0 : fflags_o) |
                     (wb_pop ? STATUS_W'(res_head.status) : '0);
      end
   end

endmodule

// File: tb/tb_fp_result_wb.sv
// Bench for fp_result_wb: directed literal scenarios, then randomized traffic checked
// every cycle against a queue-based model of the writeback rules.
module tb_fp_result_wb;

   localparam int TAG_DEPTH = 4;
   localparam int RES_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_to_int;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        fpu_valid, fpu_ready;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_status;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        frf_we, irf_we;
   logic [4:0]  frf_waddr, irf_waddr;
   logic [31:0] frf_wdata, irf_wdata;
   logic        flush, fflags_clr;
   logic [4:0]  fflags;
   logic        busy, err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fp_result_wb #(.TAG_DEPTH(TAG_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_rd_i(issue_rd), .issue_to_int_i(issue_to_int),
      .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready),
      .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
      .ld_valid_i(ld_valid), .ld_rd_i(ld_rd), .ld_data_i(ld_data),
      .frf_we_o(frf_we), .frf_waddr_o(frf_waddr), .frf_wdata_o(frf_wdata),
      .irf_we_o(irf_we), .irf_waddr_o(irf_waddr), .irf_wdata_o(irf_wdata),
      .flush_i(flush), .fflags_clr_i(fflags_clr), .fflags_o(fflags),
      .busy_o(busy), .err_o(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [5:0]  tag_q[$];   // {rd, to_int}
   logic [36:0] res_q[$];   // {result, status}
   logic        m_frf_we, m_irf_we, m_err;
   logic [4:0]  m_frf_waddr, m_irf_waddr, m_fflags;
   logic [31:0] m_frf_wdata, m_irf_wdata;
   bit          model_ok = 0;

   always @(posedge clk) begin
      logic iss, fp, pop;
      logic [5:0]  t;
      logic [36:0] r;
      if (rst) begin
         tag_q.delete();
         res_q.delete();
         m_frf_we = 0; m_irf_we = 0; m_err = 0; m_fflags = 0;
         m_frf_waddr = 0; m_irf_waddr = 0; m_frf_wdata = 0; m_irf_wdata = 0;
      end else begin
         iss = issue_valid && (tag_q.size() < TAG_DEPTH) && !flush;
         fp  = fpu_valid && (res_q.size() < RES_DEPTH) && !flush;
         pop = !ld_valid && !flush && (tag_q.size() != 0) && (res_q.size() != 0);
         m_frf_we = 0; m_irf_we = 0;
         m_frf_waddr = 0; m_irf_waddr = 0; m_frf_wdata = 0; m_irf_wdata = 0;
         m_err = fp && (tag_q.size() == 0) && !iss;
         if (fflags_clr) m_fflags = 0;
         if (ld_valid) begin
            m_frf_we = 1; m_frf_waddr = ld_rd; m_frf_wdata = ld_data;
         end else if (pop) begin
            t = tag_q.pop_front();
            r = res_q.pop_front();
            if (t[0]) begin
               m_irf_we = 1; m_irf_waddr = t[5:1]; m_irf_wdata = r[36:5];
            end else begin
               m_frf_we = 1; m_frf_waddr = t[5:1]; m_frf_wdata = r[36:5];
            end
            m_fflags = m_fflags | r[4:0];
         end
         if (flush) begin
            tag_q.delete();
            res_q.delete();
         end else begin
            if (iss) tag_q.push_back({issue_rd, issue_to_int});
            if (fp && !m_err) res_q.push_back({fpu_result, fpu_status});
         end
      end
      model_ok = 1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("frf_we", frf_we, m_frf_we);
         check("frf_waddr", frf_waddr, m_frf_waddr);
         check("frf_wdata", frf_wdata, m_frf_wdata);
         check("irf_we", irf_we, m_irf_we);
         check("irf_waddr", irf_waddr, m_irf_waddr);
         check("irf_wdata", irf_wdata, m_irf_wdata);
         check("err", err, m_err);
         check("fflags", fflags, m_fflags);
         check("busy", busy, (tag_q.size() != 0) || (res_q.size() != 0));
         check("issue_ready", issue_ready, tag_q.size() < TAG_DEPTH);
         check("fpu_ready", fpu_ready, res_q.size() < RES_DEPTH);
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; issue_rd = 0; issue_to_int = 0;
      fpu_valid = 0; fpu_result = 0; fpu_status = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
      flush = 0; fflags_clr = 0;
   endtask

   task automatic send_res(input logic [31:0] res, input logic [4:0] st);
      fpu_valid = 1; fpu_result = res; fpu_status = st;
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (3) step();
      check("rst_frf_we", frf_we, 0);
      check("rst_irf_we", irf_we, 0);
      check("rst_err", err, 0);
      check("rst_fflags", fflags, 0);
      check("rst_busy", busy, 0);
      check("rst_issue_ready", issue_ready, 1);
      check("rst_fpu_ready", fpu_ready, 1);
      rst = 0;

      // Basic FP write, one cycle after result acceptance
      issue_valid = 1; issue_rd = 3; step(); idle();
      send_res(32'h3F80_0000, 5'h00); step(); idle();
      check("basic_no_early_wr", frf_we, 0);
      step();
      check("basic_we", frf_we, 1);
      check("basic_waddr", frf_waddr, 3);
      check("basic_wdata", frf_wdata, 32'h3F80_0000);

      // Load wins over a pending FPU result, which follows next cycle
      issue_valid = 1; issue_rd = 2; send_res(32'h1234_5678, 5'h00); step(); idle();
      ld_valid = 1; ld_rd = 7; ld_data = 32'h4000_0000; step(); idle();
      check("ld_first_waddr", frf_waddr, 7);
      check("ld_first_wdata", frf_wdata, 32'h4000_0000);
      step();
      check("fpu_after_ld_we", frf_we, 1);
      check("fpu_after_ld_waddr", frf_waddr, 2);
      check("fpu_after_ld_wdata", frf_wdata, 32'h1234_5678);

      // Tag FIFO fills, then frees one slot after a pop
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1; issue_rd = 5'(10 + i); issue_to_int = (i == 1); step();
      end
      idle();
      check("tags_full_ready", issue_ready, 0);
      send_res(32'hAAAA_0001, 5'h00); step(); idle();
      check("tags_full_before_pop", issue_ready, 0);
      step();
      check("tags_ready_after_pop", issue_ready, 1);
      check("tags_pop_waddr", frf_waddr, 10);

      // Sticky flags across two results; rd 11 goes to the integer RF
      send_res(32'h0000_00B0, 5'h01); step();
      send_res(32'h0000_00B1, 5'h10); step();
      check("int_we", irf_we, 1);
      check("int_waddr", irf_waddr, 11);
      check("int_wdata", irf_wdata, 32'h0000_00B0);
      check("int_no_frf", frf_we, 0);
      send_res(32'h0000_00B2, 5'h00); step(); idle();
      step();
      check("fflags_sticky", fflags, 5'h11);
      check("drained_busy", busy, 0);

      // Orphan result: error pulse, no write, flags untouched
      send_res(32'h0000_DEAD, 5'h04); step(); idle();
      check("orphan_err", err, 1);
      step();
      check("orphan_err_pulse", err, 0);
      check("orphan_no_frf", frf_we, 0);
      check("orphan_no_irf", irf_we, 0);
      check("orphan_fflags", fflags, 5'h11);

      // Flush with two pending tags; same-cycle load still written
      issue_valid = 1; issue_rd = 5; step();
      issue_rd = 6; step(); idle();
      check("preflush_busy", busy, 1);
      flush = 1; ld_valid = 1; ld_rd = 9; ld_data = 32'hCAFE_F00D; step(); idle();
      check("flush_busy", busy, 0);
      check("flush_fflags", fflags, 5'h11);
      check("flush_ld_we", frf_we, 1);
      check("flush_ld_waddr", frf_waddr, 9);

      fflags_clr = 1; step(); idle();
      check("fflags_clr", fflags, 5'h00);

      // Reset in the middle of traffic discards pending state
      issue_valid = 1; issue_rd = 4; send_res(32'h1, 5'h1); step(); idle();
      rst = 1; step(); rst = 0;
      check("midrst_busy", busy, 0);
      check("midrst_fflags", fflags, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         rst          = ($urandom_range(0, 199) == 0);
         issue_valid  = ($urandom_range(0, 1) == 1);
         issue_rd     = 5'($urandom_range(0, 31));
         issue_to_int = ($urandom_range(0, 3) == 0);
         fpu_valid    = ($urandom_range(0, 1) == 1);
         fpu_result   = $urandom;
         fpu_status   = 5'($urandom_range(0, 31));
         ld_valid     = ($urandom_range(0, 4) == 0);
         ld_rd        = 5'($urandom_range(0, 31));
         ld_data      = $urandom;
         flush        = ($urandom_range(0, 49) == 0);
         fflags_clr   = ($urandom_range(0, 29) == 0);
         step();
      end
      idle();
      rst = 0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
